// File: rtl/lcd_write_engine.sv
// HD44780 write engine: turns GO toggles in the core's LCD register word into timed
// RS/DATA setup, EN pulse, hold and command-execution wait, with busy flag and write count.
module lcd_write_engine #(
    parameter int SETUP_CYC = 4,
    parameter int EN_CYC    = 25,
    parameter int HOLD_CYC  = 2,
    parameter int EXEC_CYC  = 2000,
    parameter int LONG_CYC  = 76000,
    parameter int CNT_W     = 17
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_lcd_word,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data,
    output logic        o_busy,
    output logic [15:0] o_wr_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] L_EN    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] L_EXEC  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] L_LONG  = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_go_seen;
    logic              r_rs;
    logic [7:0]        r_data;
    logic              r_long;
    logic              r_en;
    logic              r_busy;
    logic              r_on;
    logic [15:0]       r_wr_cnt;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_accept;
    logic              w_done;
    logic              w_req;
    logic              w_long;
    logic              w_en_nxt;
    logic              w_busy_nxt;
    logic              w_cnt_zero;

    // Only ON, GO, RS and DATA are meaningful in the core's register word.
    logic w_unused;
    assign w_unused = &{1'b0, i_lcd_word[29:10], i_lcd_word[8]};

    assign w_req      = (i_lcd_word[30] != r_go_seen);
    assign w_cnt_zero = (r_cnt == '0);
    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    assign w_long     = ~i_lcd_word[9] &&
                        ((i_lcd_word[7:0] == 8'h01) || (i_lcd_word[7:1] == 7'h01));

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_go_seen <= 1'b0;
            r_rs      <= 1'b0;
            r_data    <= 8'h00;
            r_long    <= 1'b0;
            r_en      <= 1'b0;
            r_busy    <= 1'b0;
            r_on      <= 1'b0;
            r_wr_cnt  <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_en    <= w_en_nxt;
            r_busy  <= w_busy_nxt;
            r_on    <= i_lcd_word[31];
            if (w_accept) begin
                r_go_seen <= i_lcd_word[30];
                r_rs      <= i_lcd_word[9];
                r_data    <= i_lcd_word[7:0];
                r_long    <= w_long;
            end
            if (w_done) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
        end
    end

    // NOTE: every signal assigned in a combinational block gets a default first,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = L_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_PULSE;
                    w_cnt_nxt   = L_EN;
                end else begin
                    w_cnt_nxt = r_cnt - L_ONE;
                end
            end
            ST_PULSE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = L_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - L_ONE;
                end
            end
            ST_HOLD: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = r_long ? L_LONG : L_EXEC;
                end else begin
                    w_cnt_nxt = r_cnt - L_ONE;
                end
            end
            ST_WAIT: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - L_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they align exactly with the state.
    always_comb begin
        w_en_nxt   = (w_state_nxt == ST_PULSE);
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign o_lcd_on   = r_on;
    assign o_lcd_en   = r_en;
    assign o_lcd_rs   = r_rs;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_data = r_data;
    assign o_busy     = r_busy;
    assign o_wr_cnt   = r_wr_cnt;

endmodule

// File: tb/tb_lcd_write_engine.sv
// Self-checking bench for lcd_write_engine: directed timing checks plus random GO/ON traffic
// compared every cycle against a busy-time reference model.
module tb_lcd_write_engine;

    localparam int SETUP = 2;
    localparam int EN    = 3;
    localparam int HOLD  = 1;
    localparam int EXEC  = 5;
    localparam int LONG  = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] word = 32'h0;
    logic        o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_busy;
    logic [7:0]  o_lcd_data;
    logic [15:0] o_wr_cnt;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;
    logic m_preload = 1'b0;

    lcd_write_engine #(
        .SETUP_CYC(SETUP), .EN_CYC(EN), .HOLD_CYC(HOLD),
        .EXEC_CYC(EXEC), .LONG_CYC(LONG), .CNT_W(17)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_lcd_word(word),
        .o_lcd_on(o_lcd_on), .o_lcd_en(o_lcd_en), .o_lcd_rs(o_lcd_rs),
        .o_lcd_rw(o_lcd_rw), .o_lcd_data(o_lcd_data), .o_busy(o_busy),
        .o_wr_cnt(o_wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a write occupies a fixed number of busy cycles; EN is high for
    // the EN window counted from the start of that busy period.
    function automatic int write_len(input logic rs, input logic [7:0] data);
        logic is_long;
        is_long = !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
        return SETUP + EN + HOLD + (is_long ? LONG : EXEC);
    endfunction

    int          m_left;
    int          m_total;
    logic        m_go, m_rs, m_on;
    logic [7:0]  m_data;
    logic [15:0] m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0; m_total <= 0; m_go <= 1'b0; m_rs <= 1'b0;
            m_on <= 1'b0; m_data <= 8'h00; m_cnt <= 16'h0;
        end else begin
            m_on <= word[31];
            if (m_preload) begin
                m_cnt <= 16'hFFFF;
            end else if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) m_cnt <= m_cnt + 16'd1;
            end else if (word[30] != m_go) begin
                m_go    <= word[30];
                m_rs    <= word[9];
                m_data  <= word[7:0];
                m_total <= write_len(word[9], word[7:0]);
                m_left  <= write_len(word[9], word[7:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int idx;
            logic exp_en;
            idx    = m_total - m_left;
            exp_en = (m_left != 0) && (idx >= SETUP) && (idx < SETUP + EN);
            check("cyc_busy", o_busy, (m_left != 0));
            check("cyc_en", o_lcd_en, exp_en);
            check("cyc_rs", o_lcd_rs, m_rs);
            check("cyc_data", o_lcd_data, m_data);
            check("cyc_on", o_lcd_on, m_on);
            check("cyc_rw", o_lcd_rw, 1'b0);
            check("cyc_wrcnt", o_wr_cnt, m_cnt);
        end
    end

    task automatic wait_idle(input string tag);
        int n = 0;
        while (o_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, o_busy, 1'b0);
    endtask

    // Toggles GO with the given RS/DATA and measures the resulting bus cycle.
    task automatic do_write(input logic rs, input logic [7:0] data, input int exp_busy,
                            input string tag);
        int busy_n = 0;
        int en_n = 0;
        int en_first = -1;
        logic seen = 1'b0;
        @(negedge clk);
        word[30]  = ~word[30];
        word[9]   = rs;
        word[7:0] = data;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (o_busy) begin
                busy_n++;
                seen = 1'b1;
                if (o_lcd_rs !== rs || o_lcd_data !== data) check({tag, "_stable"}, {o_lcd_rs, o_lcd_data}, {rs, data});
            end
            if (o_lcd_en) begin
                en_n++;
                if (en_first < 0) en_first = busy_n - 1;
            end
            if (seen && !o_busy) break;
        end
        check({tag, "_busy_len"}, busy_n, exp_busy);
        check({tag, "_en_len"}, en_n, EN);
        check({tag, "_en_off"}, en_first, SETUP);
    endtask

    initial begin
        int n, gap;
        logic seen;

        // Reset state
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", o_busy, 1'b0);
        check("rst_en", o_lcd_en, 1'b0);
        check("rst_data", o_lcd_data, 8'h00);
        check("rst_cnt", o_wr_cnt, 16'h0);
        rst_n = 1'b1;

        // Reset during PULSE abandons the write
        @(negedge clk);
        word = 32'h0; word[30] = 1'b1; word[9] = 1'b1; word[7:0] = 8'h41;
        n = 0;
        do begin @(negedge clk); n++; end while (!o_lcd_en && n < 20);
        check("pre_rst_en", o_lcd_en, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_en", o_lcd_en, 1'b0);
        check("mid_rst_busy", o_busy, 1'b0);
        check("mid_rst_cnt", o_wr_cnt, 16'h0);
        word = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed writes: normal, clear, home, RS=1 with 0x01
        do_write(1'b1, 8'h41, SETUP + EN + HOLD + EXEC, "w41");
        check("w41_cnt", o_wr_cnt, 16'd1);
        do_write(1'b0, 8'h01, SETUP + EN + HOLD + LONG, "clr");
        do_write(1'b0, 8'h03, SETUP + EN + HOLD + LONG, "home");
        do_write(1'b1, 8'h01, SETUP + EN + HOLD + EXEC, "rs1_01");
        check("dir_cnt", o_wr_cnt, 16'd4);

        // RS/DATA change without GO toggle has no effect
        @(negedge clk);
        word[9] = 1'b0; word[7:0] = 8'h99;
        repeat (3) @(negedge clk);
        check("nogo_busy", o_busy, 1'b0);
        check("nogo_data", o_lcd_data, 8'h01);

        // Toggle during WAIT: second write after exactly one IDLE cycle
        @(negedge clk);
        word[30] = ~word[30]; word[9] = 1'b1; word[7:0] = 8'h10;
        repeat (8) @(negedge clk);
        word[30] = ~word[30]; word[7:0] = 8'h42;
        n = 0;
        while (o_busy && n < 40) begin @(negedge clk); n++; end
        gap = 0;
        while (!o_busy && gap < 10) begin gap++; @(negedge clk); end
        check("queued_gap", gap, 1);
        check("queued_data", o_lcd_data, 8'h42);
        wait_idle("queued");

        // Two toggles during WAIT cancel
        @(negedge clk);
        word[30] = ~word[30]; word[7:0] = 8'h11;
        repeat (8) @(negedge clk);
        word[30] = ~word[30];
        @(negedge clk);
        word[30] = ~word[30];
        n = 0;
        while (o_busy && n < 40) begin @(negedge clk); n++; end
        seen = 1'b0;
        repeat (6) begin @(negedge clk); seen |= o_busy; end
        check("cancel_busy", seen, 1'b0);

        // ON follows bit 31 one cycle later while busy
        @(negedge clk);
        word[30] = ~word[30]; word[7:0] = 8'h20;
        repeat (3) @(negedge clk);
        word[31] = 1'b1;
        @(negedge clk);
        check("on_follow", o_lcd_on, 1'b1);
        word[31] = 1'b0;
        @(negedge clk);
        check("on_drop", o_lcd_on, 1'b0);
        wait_idle("on");

        // Counter wrap
        @(negedge clk);
        chk_en = 1'b0;
        force dut.r_wr_cnt = 16'hFFFF;
        m_preload = 1'b1;
        @(negedge clk);
        release dut.r_wr_cnt;
        m_preload = 1'b0;
        @(negedge clk);
        check("preload", o_wr_cnt, 16'hFFFF);
        chk_en = 1'b1;
        do_write(1'b1, 8'h55, SETUP + EN + HOLD + EXEC, "wrap");
        check("wrap_cnt", o_wr_cnt, 16'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 15))
                0, 1: begin
                    word[30] = ~word[30];
                    word[9]  = 1'($urandom_range(0, 1));
                    case ($urandom_range(0, 3))
                        0: word[7:0] = 8'h01;
                        1: word[7:0] = 8'($urandom_range(2, 3));
                        default: word[7:0] = 8'($urandom);
                    endcase
                end
                2: word[31] = ~word[31];
                3: begin
                    word[29:0] = 30'($urandom);
                end
                default: ;
            endcase
        end
        wait_idle("rand");
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
